// File: rtl/dmem_arbiter.sv
// Two-port request/acknowledge arbiter and sequencer for a single-port data memory.
// Each access runs IDLE (grant) -> ACCESS (one strobe cycle) -> DONE (ack pulse).
module dmem_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int FIXED_PRI = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // Handshake: a requester raises req with we/addr/wdata stable and holds them
  // until the single-cycle ack; a req still high after ack is a new request.
  input  logic              a_req_i,
  input  logic              a_we_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  output logic              a_ack_o,
  output logic [DATA_W-1:0] a_rdata_o,
  input  logic              b_req_i,
  input  logic              b_we_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_wdata_i,
  output logic              b_ack_o,
  output logic [DATA_W-1:0] b_rdata_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t              state_q;
  logic                cmd_port_q;   // 0 = port A, 1 = port B
  logic                cmd_we_q;
  logic [ADDR_W-1:0]   cmd_addr_q;
  logic [DATA_W-1:0]   cmd_wdata_q;
  logic                ptr_q;        // round-robin pointer: port that wins a tie
  logic                mem_read_q;
  logic                mem_write_q;
  logic                a_ack_q;
  logic                b_ack_q;
  logic                busy_q;
  logic [DATA_W-1:0]   a_rdata_q;
  logic [DATA_W-1:0]   b_rdata_q;

  logic                grant_b_d;
  logic                sel_we_d;
  logic [ADDR_W-1:0]   sel_addr_d;
  logic [DATA_W-1:0]   sel_wdata_d;

  always_comb begin
    grant_b_d = 1'b0;
    if (b_req_i && !a_req_i) begin
      grant_b_d = 1'b1;
    end else if (a_req_i && b_req_i) begin
      grant_b_d = (FIXED_PRI == 0) ? ptr_q : 1'b0;
    end
  end

  always_comb begin
    sel_we_d    = grant_b_d ? b_we_i    : a_we_i;
    sel_addr_d  = grant_b_d ? b_addr_i  : a_addr_i;
    sel_wdata_d = grant_b_d ? b_wdata_i : a_wdata_i;
  end

  // Strobes are registered so they are high only during ACCESS; the memory
  // writes combinationally while mem_write is high, so they must not linger.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cmd_port_q  <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      ptr_q       <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      busy_q      <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
    end else begin
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (a_req_i || b_req_i) begin
            cmd_port_q  <= grant_b_d;
            cmd_we_q    <= sel_we_d;
            cmd_addr_q  <= sel_addr_d;
            cmd_wdata_q <= sel_wdata_d;
            ptr_q       <= ~grant_b_d;
            mem_read_q  <= ~sel_we_d;
            mem_write_q <= sel_we_d;
            busy_q      <= 1'b1;
            state_q     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          if (!cmd_we_q) begin
            if (cmd_port_q) b_rdata_q <= mem_rdata_i;
            else            a_rdata_q <= mem_rdata_i;
          end
          if (cmd_port_q) b_ack_q <= 1'b1;
          else            a_ack_q <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign a_ack_o     = a_ack_q;
  assign b_ack_o     = b_ack_q;
  assign a_rdata_o   = a_rdata_q;
  assign b_rdata_o   = b_rdata_q;
  assign mem_read_o  = mem_read_q;
  assign mem_write_o = mem_write_q;
  assign mem_addr_o  = cmd_addr_q;
  assign mem_wdata_o = cmd_wdata_q;
  assign busy_o      = busy_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a round-robin and a fixed-priority instance, each with its own
// memory, checked every cycle against a transaction-timing reference model.
module tb_dmem_arbiter;

  typedef struct packed {
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
  } op_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  // index k = 2*instance + port (port 0 = A, 1 = B); instance 0 round-robin, 1 fixed
  logic        req_s   [4];
  logic        we_s    [4];
  logic [7:0]  addr_s  [4];
  logic [15:0] wdata_s [4];
  logic        ack_w   [4];
  logic [15:0] rdata_w [4];
  logic        mrd_w   [2];
  logic        mwr_w   [2];
  logic        busy_w  [2];
  logic [7:0]  maddr_w [2];
  logic [15:0] mwdata_w[2];
  logic [15:0] mrdata_w[2];
  logic [1:0]  st_w    [2];

  logic [15:0] tb_mem  [2][256];
  logic [15:0] ref_mem [2][256];

  // reference model: absolute cycle of the last grant per instance
  int          g_cyc   [2];
  logic        g_port  [2];
  logic        g_we    [2];
  logic [7:0]  g_addr  [2];
  logic [15:0] g_wdata [2];
  logic        ptr     [2];
  logic [15:0] exp_rd  [4];
  int          cyc;
  bit          chk_en;
  op_t         op_q    [4][$];
  int          ack_log [2][$];
  int          ack_cyc [2][$];
  int          checks;
  int          errors;

  always #5 clk = ~clk;

  assign mrdata_w[0] = tb_mem[0][maddr_w[0]];
  assign mrdata_w[1] = tb_mem[1][maddr_w[1]];

  dmem_arbiter #(.ADDR_W(8), .DATA_W(16), .FIXED_PRI(0)) u_rr (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(req_s[0]), .a_we_i(we_s[0]), .a_addr_i(addr_s[0]), .a_wdata_i(wdata_s[0]),
    .a_ack_o(ack_w[0]), .a_rdata_o(rdata_w[0]),
    .b_req_i(req_s[1]), .b_we_i(we_s[1]), .b_addr_i(addr_s[1]), .b_wdata_i(wdata_s[1]),
    .b_ack_o(ack_w[1]), .b_rdata_o(rdata_w[1]),
    .mem_read_o(mrd_w[0]), .mem_write_o(mwr_w[0]), .mem_addr_o(maddr_w[0]),
    .mem_wdata_o(mwdata_w[0]), .mem_rdata_i(mrdata_w[0]),
    .busy_o(busy_w[0]), .dbg_state_o(st_w[0])
  );

  dmem_arbiter #(.ADDR_W(8), .DATA_W(16), .FIXED_PRI(1)) u_fp (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(req_s[2]), .a_we_i(we_s[2]), .a_addr_i(addr_s[2]), .a_wdata_i(wdata_s[2]),
    .a_ack_o(ack_w[2]), .a_rdata_o(rdata_w[2]),
    .b_req_i(req_s[3]), .b_we_i(we_s[3]), .b_addr_i(addr_s[3]), .b_wdata_i(wdata_s[3]),
    .b_ack_o(ack_w[3]), .b_rdata_o(rdata_w[3]),
    .mem_read_o(mrd_w[1]), .mem_write_o(mwr_w[1]), .mem_addr_o(maddr_w[1]),
    .mem_wdata_o(mwdata_w[1]), .mem_rdata_i(mrdata_w[1]),
    .busy_o(busy_w[1]), .dbg_state_o(st_w[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic op_t mk_op(input logic we, input logic [7:0] addr, input logic [15:0] wdata);
    op_t o;
    o.we    = we;
    o.addr  = addr;
    o.wdata = wdata;
    return o;
  endfunction

  function automatic op_t rand_op();
    int sel;
    logic [7:0] a;
    sel = $urandom_range(0, 9);
    a = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom_range(0, 255));
    return mk_op(1'($urandom_range(0, 1)), a, 16'($urandom));
  endfunction

  function automatic bit any_pending();
    return (op_q[0].size() + op_q[1].size() + op_q[2].size() + op_q[3].size()) != 0;
  endfunction

  task automatic drive();
    for (int k = 0; k < 4; k++) begin
      if (op_q[k].size() > 0) begin
        req_s[k]   = 1'b1;
        we_s[k]    = op_q[k][0].we;
        addr_s[k]  = op_q[k][0].addr;
        wdata_s[k] = op_q[k][0].wdata;
      end else begin
        req_s[k] = 1'b0;
      end
    end
  endtask

  task automatic check_cycle();
    for (int d = 0; d < 2; d++) begin
      bit in_acc;
      bit in_done;
      in_acc  = (cyc == g_cyc[d] + 1);
      in_done = (cyc == g_cyc[d] + 2);
      chk($sformatf("d%0d_mem_read_c%0d", d, cyc), mrd_w[d], in_acc && !g_we[d]);
      chk($sformatf("d%0d_mem_write_c%0d", d, cyc), mwr_w[d], in_acc && g_we[d]);
      chk($sformatf("d%0d_busy_c%0d", d, cyc), busy_w[d], in_acc || in_done);
      chk($sformatf("d%0d_a_ack_c%0d", d, cyc), ack_w[2*d], in_done && !g_port[d]);
      chk($sformatf("d%0d_b_ack_c%0d", d, cyc), ack_w[2*d+1], in_done && g_port[d]);
      chk($sformatf("d%0d_a_rdata_c%0d", d, cyc), rdata_w[2*d], exp_rd[2*d]);
      chk($sformatf("d%0d_b_rdata_c%0d", d, cyc), rdata_w[2*d+1], exp_rd[2*d+1]);
      chk($sformatf("d%0d_mem_addr_c%0d", d, cyc), maddr_w[d], g_addr[d]);
      chk($sformatf("d%0d_mem_wdata_c%0d", d, cyc), mwdata_w[d], g_wdata[d]);
      if (ack_w[2*d] === 1'b1)   begin ack_log[d].push_back(0); ack_cyc[d].push_back(cyc); end
      if (ack_w[2*d+1] === 1'b1) begin ack_log[d].push_back(1); ack_cyc[d].push_back(cyc); end
    end
  endtask

  // Model of what the coming clock edge does: grant at an idle edge, memory effect
  // one cycle later, retire the request one cycle after that.
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        g_cyc[d] = -100; g_port[d] = 1'b0; g_we[d] = 1'b0;
        g_addr[d] = 8'h00; g_wdata[d] = 16'h0000; ptr[d] = 1'b0;
        exp_rd[2*d] = 16'h0000; exp_rd[2*d+1] = 16'h0000;
      end else begin
        if (cyc == g_cyc[d] + 1) begin
          if (g_we[d]) ref_mem[d][g_addr[d]] = g_wdata[d];
          else         exp_rd[2*d + int'(g_port[d])] = ref_mem[d][g_addr[d]];
        end
        if (cyc == g_cyc[d] + 2) begin
          void'(op_q[2*d + int'(g_port[d])].pop_front());
        end else if (cyc > g_cyc[d] + 2) begin
          bit ra, rb, win;
          ra = op_q[2*d].size() > 0;
          rb = op_q[2*d+1].size() > 0;
          if (ra || rb) begin
            if (ra && rb) win = (d == 1) ? 1'b0 : ptr[d];
            else          win = rb;
            g_port[d]  = win;
            g_we[d]    = op_q[2*d + int'(win)][0].we;
            g_addr[d]  = op_q[2*d + int'(win)][0].addr;
            g_wdata[d] = op_q[2*d + int'(win)][0].wdata;
            g_cyc[d]   = cyc;
            ptr[d]     = ~win;
          end
        end
      end
    end
    cyc++;
  endtask

  task automatic tick();
    bit          wr_en [2];
    logic [7:0]  wr_a  [2];
    logic [15:0] wr_d  [2];
    drive();
    @(negedge clk);
    if (chk_en) check_cycle();
    for (int d = 0; d < 2; d++) begin
      wr_en[d] = (mwr_w[d] === 1'b1);
      wr_a[d]  = maddr_w[d];
      wr_d[d]  = mwdata_w[d];
    end
    model_edge();
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) if (wr_en[d]) tb_mem[d][wr_a[d]] = wr_d[d];
  endtask

  task automatic run_until_empty(input int budget, input string tag);
    int n;
    n = 0;
    while (any_pending() && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_drain_timeout"}, 32'(any_pending()), 32'd0);
  endtask

  task automatic clear_logs();
    for (int d = 0; d < 2; d++) begin
      ack_log[d].delete();
      ack_cyc[d].delete();
    end
  endtask

  initial begin
    int exp_rr [4];
    int exp_fp [4];
    checks = 0; errors = 0; cyc = 0; chk_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req_s[k] = 1'b0; we_s[k] = 1'b0; addr_s[k] = 8'h00; wdata_s[k] = 16'h0000;
    end
    for (int d = 0; d < 2; d++) begin
      g_cyc[d] = -100;
      for (int i = 0; i < 256; i++) begin
        tb_mem[d][i]  = 16'($urandom);
        ref_mem[d][i] = tb_mem[d][i];
      end
    end

    // reset
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;

    // single read by A
    for (int d = 0; d < 2; d++) begin
      tb_mem[d][8'h10] = 16'hBEEF; ref_mem[d][8'h10] = 16'hBEEF;
      op_q[2*d].push_back(mk_op(1'b0, 8'h10, 16'h0000));
    end
    clear_logs();
    run_until_empty(20, "single_read");
    tick();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_single_read_data", d), rdata_w[2*d], 32'h0000BEEF);
      chk($sformatf("d%0d_single_read_nacks", d), ack_log[d].size(), 1);
      chk($sformatf("d%0d_single_read_port", d), ack_log[d][0], 0);
    end

    // B writes 0x1234 to 0xFF, then reads it back
    for (int d = 0; d < 2; d++) begin
      op_q[2*d+1].push_back(mk_op(1'b1, 8'hFF, 16'h1234));
      op_q[2*d+1].push_back(mk_op(1'b0, 8'hFF, 16'h0000));
    end
    clear_logs();
    run_until_empty(20, "b_wr_rd");
    tick();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_b_rd_data", d), rdata_w[2*d+1], 32'h00001234);
      chk($sformatf("d%0d_b_mem_ff", d), tb_mem[d][8'hFF], 32'h00001234);
      chk($sformatf("d%0d_a_rdata_kept", d), rdata_w[2*d], 32'h0000BEEF);
      chk($sformatf("d%0d_b_nacks", d), ack_log[d].size(), 2);
    end

    // contention: round-robin alternates, fixed priority serves A three times first
    exp_rr[0] = 0; exp_rr[1] = 1; exp_rr[2] = 0; exp_rr[3] = 1;
    exp_fp[0] = 0; exp_fp[1] = 0; exp_fp[2] = 0; exp_fp[3] = 1;
    op_q[0].push_back(rand_op()); op_q[0].push_back(rand_op());
    op_q[1].push_back(rand_op()); op_q[1].push_back(rand_op());
    for (int i = 0; i < 3; i++) op_q[2].push_back(rand_op());
    op_q[3].push_back(rand_op());
    clear_logs();
    run_until_empty(60, "contention");
    tick();
    chk("rr_nacks", ack_log[0].size(), 4);
    chk("fp_nacks", ack_log[1].size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < ack_log[0].size()) chk($sformatf("rr_order_%0d", i), ack_log[0][i], exp_rr[i]);
      if (i < ack_log[1].size()) chk($sformatf("fp_order_%0d", i), ack_log[1][i], exp_fp[i]);
    end
    for (int d = 0; d < 2; d++)
      for (int i = 1; i < ack_cyc[d].size(); i++)
        chk($sformatf("d%0d_ack_spacing_%0d", d, i), ack_cyc[d][i] - ack_cyc[d][i-1], 3);

    // reset during the ACCESS cycle of an A read
    op_q[0].push_back(mk_op(1'b0, 8'h10, 16'h0000));
    op_q[2].push_back(mk_op(1'b0, 8'h10, 16'h0000));
    clear_logs();
    tick();
    chk("rst_acc_in_access", mrd_w[0], 1);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) op_q[k].delete();
    tick();
    rst = 1'b0;
    chk("rst_acc_busy", busy_w[0], 0);
    chk("rst_acc_strobe", mrd_w[0], 0);
    chk("rst_acc_rdata", rdata_w[0], 0);
    repeat (4) tick();
    chk("rst_acc_no_ack_rr", ack_log[0].size(), 0);
    chk("rst_acc_no_ack_fp", ack_log[1].size(), 0);

    // randomized traffic on both ports of both instances
    repeat (400) begin
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 3) == 0 && op_q[k].size() < 2) op_q[k].push_back(rand_op());
      tick();
    end
    run_until_empty(300, "random");

    // idle hold
    repeat (10) tick();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_idle_busy", d), busy_w[d], 0);
      chk($sformatf("d%0d_idle_wr", d), mwr_w[d], 0);
      chk($sformatf("d%0d_idle_addr_hold", d), maddr_w[d], g_addr[d]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $fatal(1, "FAIL watchdog_timeout");
  end

endmodule
